// File: rtl/serial_frame_pkg.sv
// rtl/serial_frame_pkg.sv - shared types and helpers for the serial frame sequencer
package serial_frame_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HDR  = 2'd1,
    DATA = 2'd2,
    CONT = 2'd3
  } frame_state_t;

  // Larger of two integers, used to size the shared bit counter.
  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/frame_bit_counter.sv
// rtl/frame_bit_counter.sv - loadable bit-position counter with terminal-count compare
module frame_bit_counter #(
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  input  logic [CNT_W-1:0] term,
  output logic [CNT_W-1:0] cnt,
  output logic             tc
);

  // Clear has priority so a window boundary always restarts at bit 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tc = (cnt == term);

endmodule

// File: rtl/serial_frame_ctrl.sv
// rtl/serial_frame_ctrl.sv - start/header/data/continuation sequencer for the serial receive path
module serial_frame_ctrl
  import serial_frame_pkg::*;
#(
  parameter  int HDR_BITS  = 6,
  parameter  int DATA_BITS = 5,
  parameter  int MAX_WORDS = 4,
  localparam int CNT_W     = (max_int(HDR_BITS, DATA_BITS) > 1) ?
                             $clog2(max_int(HDR_BITS, DATA_BITS)) : 1,
  localparam int WC_W      = $clog2(MAX_WORDS + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             abort,
  input  logic             serin,
  output logic             hdr_en,
  output logic             data_en,
  output logic [CNT_W-1:0] bit_idx,
  output logic [WC_W-1:0]  word_cnt,
  output logic             word_done,
  output logic             frame_done,
  output logic             frame_err,
  output logic             busy
);

  frame_state_t     state_q;
  frame_state_t     state_d;
  logic             cnt_clr;
  logic             cnt_inc;
  logic             wc_clr;
  logic             wc_inc;
  logic             tc;
  logic [CNT_W-1:0] term;

  // One counter serves both windows; only the terminal value changes with state.
  assign term = (state_q == HDR) ? CNT_W'(HDR_BITS - 1) : CNT_W'(DATA_BITS - 1);

  frame_bit_counter #(
    .CNT_W (CNT_W)
  ) u_bit_counter (
    .clk  (clk),
    .rst  (rst),
    .clr  (cnt_clr),
    .inc  (cnt_inc),
    .term (term),
    .cnt  (bit_idx),
    .tc   (tc)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Completed-word counter; saturates so an overrun never wraps the reported count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word_cnt <= '0;
    end else if (wc_clr) begin
      word_cnt <= '0;
    end else if (wc_inc && (word_cnt != WC_W'(MAX_WORDS))) begin
      word_cnt <= word_cnt + 1'b1;
    end
  end

  // Next state, counter controls and en-qualified strobes; abort overrides everything.
  always_comb begin
    state_d    = state_q;
    cnt_clr    = 1'b0;
    cnt_inc    = 1'b0;
    wc_clr     = 1'b0;
    wc_inc     = 1'b0;
    hdr_en     = 1'b0;
    data_en    = 1'b0;
    word_done  = 1'b0;
    frame_done = 1'b0;
    frame_err  = 1'b0;
    if (abort) begin
      state_d = IDLE;
      cnt_clr = 1'b1;
      wc_clr  = 1'b1;
    end else if (en) begin
      case (state_q)
        IDLE: begin
          if (!serin) begin
            state_d = HDR;
            cnt_clr = 1'b1;
            wc_clr  = 1'b1;
          end
        end
        HDR: begin
          hdr_en = 1'b1;
          if (tc) begin
            state_d = DATA;
            cnt_clr = 1'b1;
          end else begin
            cnt_inc = 1'b1;
          end
        end
        DATA: begin
          data_en = 1'b1;
          if (tc) begin
            word_done = 1'b1;
            wc_inc    = 1'b1;
            cnt_clr   = 1'b1;
            state_d   = CONT;
          end else begin
            cnt_inc = 1'b1;
          end
        end
        CONT: begin
          cnt_clr = 1'b1;
          if (serin) begin
            frame_done = 1'b1;
            state_d    = IDLE;
          end else if (word_cnt < WC_W'(MAX_WORDS)) begin
            state_d = DATA;
          end else begin
            frame_err = 1'b1;
            state_d   = IDLE;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_serial_frame_ctrl.sv
// tb/tb_serial_frame_ctrl.sv - randomized frame-level bench for serial_frame_ctrl
module tb_serial_frame_ctrl;

  localparam int HB = 6;
  localparam int DB = 5;
  localparam int MW = 4;
  localparam int CW = 3;
  localparam int WW = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          en = 1'b0;
  logic          abort = 1'b0;
  logic          serin = 1'b1;
  logic          hdr_en;
  logic          data_en;
  logic [CW-1:0] bit_idx;
  logic [WW-1:0] word_cnt;
  logic          word_done;
  logic          frame_done;
  logic          frame_err;
  logic          busy;

  serial_frame_ctrl #(
    .HDR_BITS  (HB),
    .DATA_BITS (DB),
    .MAX_WORDS (MW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .abort      (abort),
    .serin      (serin),
    .hdr_en     (hdr_en),
    .data_en    (data_en),
    .bit_idx    (bit_idx),
    .word_cnt   (word_cnt),
    .word_done  (word_done),
    .frame_done (frame_done),
    .frame_err  (frame_err),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          hdr_en;
    logic          data_en;
    logic [CW-1:0] bit_idx;
    logic [WW-1:0] word_cnt;
    logic          word_done;
    logic          frame_done;
    logic          frame_err;
    logic          busy;
  } obs_t;

  typedef struct packed {
    logic serin;
    obs_t exp;
  } rec_t;

  rec_t q[$];
  int   compared = 0;
  int   mismatched = 0;
  int   prev_wc = 0;
  int   n_hdr, n_data, n_wd, n_fd, n_fe, fd_idx;
  int   exp_fd, exp_fe;

  function automatic obs_t mk(bit h, bit d, int bi, int wc, bit wd, bit fd, bit fe, bit b);
    obs_t o;
    o.hdr_en     = h;
    o.data_en    = d;
    o.bit_idx    = CW'(bi);
    o.word_cnt   = WW'(wc);
    o.word_done  = wd;
    o.frame_done = fd;
    o.frame_err  = fe;
    o.busy       = b;
    return o;
  endfunction

  // With en low the registered view is frozen and every strobe is silent.
  function automatic obs_t hold_of(obs_t e);
    obs_t o = e;
    o.hdr_en     = 1'b0;
    o.data_en    = 1'b0;
    o.word_done  = 1'b0;
    o.frame_done = 1'b0;
    o.frame_err  = 1'b0;
    return o;
  endfunction

  task automatic push_idle(input int n);
    rec_t r;
    for (int i = 0; i < n; i++) begin
      r.serin = 1'b1;
      r.exp   = mk(0, 0, 0, prev_wc, 0, 0, 0, 0);
      q.push_back(r);
    end
  endtask

  // Expected en-cycle sequence of one frame of k words, built from the frame layout.
  task automatic build_frame(input int k, input bit overrun);
    rec_t r;
    bit   c;
    int   wc1;
    r.serin = 1'b0;
    r.exp   = mk(0, 0, 0, prev_wc, 0, 0, 0, 0);
    q.push_back(r);
    for (int j = 0; j < HB; j++) begin
      r.serin = 1'($urandom_range(0, 1));
      r.exp   = mk(1, 0, j, 0, 0, 0, 0, 1);
      q.push_back(r);
    end
    for (int w = 0; w < k; w++) begin
      for (int j = 0; j < DB; j++) begin
        r.serin = 1'($urandom_range(0, 1));
        r.exp   = mk(0, 1, j, w, j == DB - 1, 0, 0, 1);
        q.push_back(r);
      end
      c       = (w == k - 1) ? !overrun : 1'b0;
      wc1     = (w + 1 > MW) ? MW : w + 1;
      r.serin = c;
      r.exp   = mk(0, 0, 0, wc1, 0, c, (!c && wc1 == MW), 1);
      q.push_back(r);
    end
    prev_wc = (k > MW) ? MW : k;
    if (overrun) exp_fe++;
    else exp_fd++;
  endtask

  task automatic step(input logic s, input logic e, input logic a, output obs_t got);
    @(negedge clk);
    serin = s;
    en    = e;
    abort = a;
    #1;
    got = {hdr_en, data_en, bit_idx, word_cnt, word_done, frame_done, frame_err, busy};
  endtask

  task automatic clear_tallies;
    n_hdr = 0; n_data = 0; n_wd = 0; n_fd = 0; n_fe = 0; fd_idx = -1;
    exp_fd = 0; exp_fe = 0;
  endtask

  // Plays the expected queue, optionally inserting en=0 cycles before a record.
  task automatic run_queue(input int gap_pct, input string name);
    rec_t r;
    obs_t got;
    obs_t want;
    int   idx = 0;
    while (q.size() > 0) begin
      r = q.pop_front();
      for (int g = 0; g < 3; g++) begin
        if (gap_pct > 0 && $urandom_range(0, 99) < gap_pct) begin
          step(1'($urandom_range(0, 1)), 1'b0, 1'b0, got);
          want = hold_of(r.exp);
          compared++;
          if (got !== want) begin
            mismatched++;
            $display("FAIL %s_hold[%0d]: got %h want %h", name, idx, got, want);
          end
        end
      end
      step(r.serin, 1'b1, 1'b0, got);
      compared++;
      if (got !== r.exp) begin
        mismatched++;
        $display("FAIL %s[%0d]: got %h want %h", name, idx, got, r.exp);
      end
      n_hdr  += int'(got.hdr_en);
      n_data += int'(got.data_en);
      n_wd   += int'(got.word_done);
      n_fd   += int'(got.frame_done);
      n_fe   += int'(got.frame_err);
      if (got.frame_done && fd_idx < 0) fd_idx = idx;
      idx++;
    end
  endtask

  task automatic test_reset;
    obs_t got;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    got = {hdr_en, data_en, bit_idx, word_cnt, word_done, frame_done, frame_err, busy};
    compared++;
    if (got !== obs_t'(0)) begin
      mismatched++;
      $display("FAIL reset_held: got %h want %h", got, obs_t'(0));
    end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step(1'b1, 1'b1, 1'b0, got);
      compared++;
      if (got !== obs_t'(0)) begin
        mismatched++;
        $display("FAIL reset_release[%0d]: got %h want %h", i, got, obs_t'(0));
      end
    end
    prev_wc = 0;
  endtask

  task automatic test_single_word;
    clear_tallies();
    build_frame(1, 1'b0);
    push_idle(2);
    run_queue(0, "single");
    compared++;
    if (n_hdr != HB) begin mismatched++; $display("FAIL single_hdr_count: got %0d want %0d", n_hdr, HB); end
    compared++;
    if (n_data != DB) begin mismatched++; $display("FAIL single_data_count: got %0d want %0d", n_data, DB); end
    compared++;
    if (n_wd != 1) begin mismatched++; $display("FAIL single_word_done: got %0d want 1", n_wd); end
    compared++;
    if (fd_idx != HB + DB + 1) begin
      mismatched++;
      $display("FAIL single_done_cycle: got %0d want %0d", fd_idx, HB + DB + 1);
    end
    compared++;
    if (int'(word_cnt) != 1) begin mismatched++; $display("FAIL single_word_cnt: got %0d want 1", word_cnt); end
  endtask

  task automatic test_three_words;
    clear_tallies();
    build_frame(3, 1'b0);
    push_idle(1);
    run_queue(0, "three");
    compared++;
    if (n_data != 3 * DB) begin mismatched++; $display("FAIL three_data_count: got %0d want %0d", n_data, 3 * DB); end
    compared++;
    if (n_wd != 3) begin mismatched++; $display("FAIL three_word_done: got %0d want 3", n_wd); end
    compared++;
    if (n_fd != 1 || n_fe != 0) begin
      mismatched++;
      $display("FAIL three_events: got fd=%0d fe=%0d want fd=1 fe=0", n_fd, n_fe);
    end
    compared++;
    if (int'(word_cnt) != 3) begin mismatched++; $display("FAIL three_word_cnt: got %0d want 3", word_cnt); end
  endtask

  task automatic test_overrun;
    clear_tallies();
    build_frame(MW, 1'b1);
    push_idle(1);
    run_queue(0, "overrun");
    compared++;
    if (n_fe != 1 || n_fd != 0) begin
      mismatched++;
      $display("FAIL overrun_events: got fe=%0d fd=%0d want fe=1 fd=0", n_fe, n_fd);
    end
    compared++;
    if (int'(word_cnt) != MW || busy !== 1'b0) begin
      mismatched++;
      $display("FAIL overrun_final: got wc=%0d busy=%0b want wc=%0d busy=0", word_cnt, busy, MW);
    end
  endtask

  task automatic test_en_toggle;
    clear_tallies();
    build_frame(1, 1'b0);
    push_idle(1);
    run_queue(60, "en_toggle");
    compared++;
    if (n_hdr + n_data != HB + DB) begin
      mismatched++;
      $display("FAIL en_toggle_enables: got %0d want %0d", n_hdr + n_data, HB + DB);
    end
  endtask

  task automatic test_abort;
    int   pos[3] = '{1 + HB + 3, 1 + HB + DB - 1, 1 + HB + DB};
    rec_t r;
    obs_t got;
    obs_t want;
    for (int p = 0; p < 3; p++) begin
      q.delete();
      clear_tallies();
      build_frame(1, 1'b0);
      for (int i = 0; i < pos[p]; i++) begin
        r = q.pop_front();
        step(r.serin, 1'b1, 1'b0, got);
        compared++;
        if (got !== r.exp) begin
          mismatched++;
          $display("FAIL abort_lead%0d[%0d]: got %h want %h", p, i, got, r.exp);
        end
      end
      r = q.pop_front();
      step(r.serin, 1'b1, 1'b1, got);
      want = hold_of(r.exp);
      compared++;
      if (got !== want) begin
        mismatched++;
        $display("FAIL abort_cycle%0d: got %h want %h", p, got, want);
      end
      q.delete();
      clear_tallies();
      prev_wc = 0;
      push_idle(2);
      build_frame(1, 1'b0);
      push_idle(1);
      run_queue(0, "abort_recover");
      compared++;
      if (n_fd != 1 || n_wd != 1) begin
        mismatched++;
        $display("FAIL abort_recover_events%0d: got fd=%0d wd=%0d want 1 1", p, n_fd, n_wd);
      end
    end
  endtask

  task automatic test_reset_mid_header;
    rec_t r;
    obs_t got;
    q.delete();
    clear_tallies();
    build_frame(1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      r = q.pop_front();
      step(r.serin, 1'b1, 1'b0, got);
      compared++;
      if (got !== r.exp) begin
        mismatched++;
        $display("FAIL rst_mid_lead[%0d]: got %h want %h", i, got, r.exp);
      end
    end
    rst = 1'b1;
    #1;
    got = {hdr_en, data_en, bit_idx, word_cnt, word_done, frame_done, frame_err, busy};
    compared++;
    if (got !== obs_t'(0)) begin
      mismatched++;
      $display("FAIL rst_mid_async: got %h want %h", got, obs_t'(0));
    end
    @(negedge clk);
    rst = 1'b0;
    q.delete();
    clear_tallies();
    prev_wc = 0;
    push_idle(1);
    build_frame(2, 1'b0);
    push_idle(1);
    run_queue(0, "rst_recover");
  endtask

  task automatic test_back_to_back;
    int k;
    bit ov;
    q.delete();
    clear_tallies();
    for (int f = 0; f < 20; f++) begin
      k  = int'($urandom_range(1, MW));
      ov = (k == MW) && ($urandom_range(0, 1) == 1);
      build_frame(k, ov);
    end
    push_idle(1);
    run_queue(25, "b2b");
    compared++;
    if (n_fd != exp_fd || n_fe != exp_fe) begin
      mismatched++;
      $display("FAIL b2b_events: got fd=%0d fe=%0d want fd=%0d fe=%0d", n_fd, n_fe, exp_fd, exp_fe);
    end
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_three_words();
    test_overrun();
    test_en_toggle();
    test_abort();
    test_reset_mid_header();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
